rs_group: RTL and testbench

RS_GROUP -- requirements
Module: rs_group

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/rs_entry.sv | 94 +++++++++
 rtl/rs_group.sv | 112 +++++++++++
 tb/tb_rs_group.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cpu_pkg : shared CPU constants (data/tag widths, opcode encodings)          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int c_data_w = 16;
    localparam int c_tag_w  = 4;
    localparam int c_op_w   = 4;

    localparam logic [c_op_w-1:0] c_op_mov = 4'd0;
    localparam logic [c_op_w-1:0] c_op_add = 4'd1;
    localparam logic [c_op_w-1:0] c_op_ld  = 4'd2;
    localparam logic [c_op_w-1:0] c_op_ldr = 4'd3;
    localparam logic [c_op_w-1:0] c_op_jeq = 4'd4;
    localparam logic [c_op_w-1:0] c_op_jmp = 4'd5;

endpackage
`default_nettype wire

// File: rtl/rs_entry.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rs_entry : one reservation-station slot with CDB snoop and ready flag       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module rs_entry
    import cpu_pkg::*;
#(
    parameter int TAG_W  = c_tag_w,
    parameter int DATA_W = c_data_w,
    parameter int OP_W   = c_op_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [OP_W-1:0]   wr_op,
    input  logic [3:0]        wr_rt,
    input  logic              wr_a_busy,
    input  logic [TAG_W-1:0]  wr_a_tag,
    input  logic [DATA_W-1:0] wr_a_val,
    input  logic              wr_b_busy,
    input  logic [TAG_W-1:0]  wr_b_tag,
    input  logic [DATA_W-1:0] wr_b_val,
    input  logic              free_en,
    input  logic              cdb_v,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_val,
    output logic              busy,
    output logic              ready,
    output logic [OP_W-1:0]   op,
    output logic [3:0]        rt,
    output logic [DATA_W-1:0] a_val,
    output logic [DATA_W-1:0] b_val
);

    logic              r_busy;
    logic [OP_W-1:0]   r_op;
    logic [3:0]        r_rt;
    logic [1:0]        r_valid;
    logic [TAG_W-1:0]  r_tag [2];
    logic [DATA_W-1:0] r_val [2];

    logic [1:0]        w_wr_busy;
    logic [1:0]        w_bypass;
    logic [TAG_W-1:0]  w_wr_tag [2];
    logic [DATA_W-1:0] w_wr_val [2];

    always_comb begin
        w_wr_busy   = {wr_b_busy, wr_a_busy};
        w_wr_tag[0] = wr_a_tag;
        w_wr_tag[1] = wr_b_tag;
        w_wr_val[0] = wr_a_val;
        w_wr_val[1] = wr_b_val;
        w_bypass[0] = wr_a_busy && cdb_v && (cdb_tag == wr_a_tag);
        w_bypass[1] = wr_b_busy && cdb_v && (cdb_tag == wr_b_tag);
    end

    // Allocation only targets free slots and issue only frees busy ones, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (wr_en) begin
            r_busy <= 1'b1;
        end else if (free_en) begin
            r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_op <= wr_op;
            r_rt <= wr_rt;
        end
        for (int k = 0; k < 2; k++) begin
            if (wr_en) begin
                r_valid[k] <= !w_wr_busy[k] || w_bypass[k];
                r_tag[k]   <= w_wr_tag[k];
                r_val[k]   <= w_wr_busy[k] ? cdb_val : w_wr_val[k];
            end else if (r_busy && !r_valid[k] && cdb_v && (cdb_tag == r_tag[k])) begin
                r_valid[k] <= 1'b1;
                r_val[k]   <= cdb_val;
            end
        end
    end

    assign busy  = r_busy;
    assign ready = r_busy && r_valid[0] && r_valid[1];
    assign op    = r_op;
    assign rt    = r_rt;
    assign a_val = r_val[0];
    assign b_val = r_val[1];

endmodule
`default_nettype wire

// File: rtl/rs_group.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rs_group : reservation-station group, allocation and lowest-index issue     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module rs_group
    import cpu_pkg::*;
#(
    parameter int N_ENTRIES = 4,
    parameter int ID_BASE   = 0,
    parameter int TAG_W     = c_tag_w,
    parameter int DATA_W    = c_data_w,
    parameter int OP_W      = c_op_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_v,
    input  logic [OP_W-1:0]   disp_op,
    input  logic              disp_a_busy,
    input  logic              disp_b_busy,
    input  logic [TAG_W-1:0]  disp_a_tag,
    input  logic [TAG_W-1:0]  disp_b_tag,
    input  logic [DATA_W-1:0] disp_a_val,
    input  logic [DATA_W-1:0] disp_b_val,
    input  logic [3:0]        disp_rt,
    output logic              full,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_v,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_val,
    output logic              fu_v,
    input  logic              fu_ready,
    output logic [OP_W-1:0]   fu_op,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    output logic [TAG_W-1:0]  fu_tag,
    output logic [3:0]        fu_rt
);

    localparam int c_idx_w = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    typedef logic [c_idx_w-1:0] idx_t;

    logic [N_ENTRIES-1:0] w_busy;
    logic [N_ENTRIES-1:0] w_ready;
    logic [N_ENTRIES-1:0] w_wr_en;
    logic [N_ENTRIES-1:0] w_free_en;
    logic [OP_W-1:0]      w_op    [N_ENTRIES];
    logic [3:0]           w_rt    [N_ENTRIES];
    logic [DATA_W-1:0]    w_a_val [N_ENTRIES];
    logic [DATA_W-1:0]    w_b_val [N_ENTRIES];
    idx_t                 w_alloc_idx;
    idx_t                 w_issue_idx;
    logic                 w_accept;
    logic                 w_issue;

    // Descending scan so the lowest matching index wins for both free and ready slots.
    always_comb begin
        w_alloc_idx = '0;
        w_issue_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!w_busy[i]) w_alloc_idx = idx_t'(i);
            if (w_ready[i]) w_issue_idx = idx_t'(i);
        end
    end

    assign full      = &w_busy;
    assign fu_v      = |w_ready;
    assign w_accept  = disp_v && !full;
    assign w_issue   = fu_v && fu_ready;
    assign alloc_tag = TAG_W'(ID_BASE) + TAG_W'(w_alloc_idx);

    assign fu_op  = w_op[w_issue_idx];
    assign fu_rt  = w_rt[w_issue_idx];
    assign fu_a   = w_a_val[w_issue_idx];
    assign fu_b   = w_b_val[w_issue_idx];
    assign fu_tag = TAG_W'(ID_BASE) + TAG_W'(w_issue_idx);

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
        assign w_wr_en[g]   = w_accept && (w_alloc_idx == idx_t'(g));
        assign w_free_en[g] = w_issue && (w_issue_idx == idx_t'(g));

        rs_entry #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W),
            .OP_W   (OP_W)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (w_wr_en[g]),
            .wr_op     (disp_op),
            .wr_rt     (disp_rt),
            .wr_a_busy (disp_a_busy),
            .wr_a_tag  (disp_a_tag),
            .wr_a_val  (disp_a_val),
            .wr_b_busy (disp_b_busy),
            .wr_b_tag  (disp_b_tag),
            .wr_b_val  (disp_b_val),
            .free_en   (w_free_en[g]),
            .cdb_v     (cdb_v),
            .cdb_tag   (cdb_tag),
            .cdb_val   (cdb_val),
            .busy      (w_busy[g]),
            .ready     (w_ready[g]),
            .op        (w_op[g]),
            .rt        (w_rt[g]),
            .a_val     (w_a_val[g]),
            .b_val     (w_b_val[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_group.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_rs_group : directed and random stimulus against a slot-level model       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_rs_group;
    import cpu_pkg::*;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 16;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_v, disp_a_busy, disp_b_busy;
    logic [OW-1:0] disp_op;
    logic [TW-1:0] disp_a_tag, disp_b_tag;
    logic [DW-1:0] disp_a_val, disp_b_val;
    logic [3:0]    disp_rt;
    logic          full;
    logic [TW-1:0] alloc_tag;
    logic          cdb_v;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_val;
    logic          fu_v, fu_ready;
    logic [OW-1:0] fu_op;
    logic [DW-1:0] fu_a, fu_b;
    logic [TW-1:0] fu_tag;
    logic [3:0]    fu_rt;

    always #5 clk = ~clk;

    rs_group #(.N_ENTRIES(N), .ID_BASE(0), .TAG_W(TW), .DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .rst(rst),
        .disp_v(disp_v), .disp_op(disp_op),
        .disp_a_busy(disp_a_busy), .disp_b_busy(disp_b_busy),
        .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag),
        .disp_a_val(disp_a_val), .disp_b_val(disp_b_val),
        .disp_rt(disp_rt), .full(full), .alloc_tag(alloc_tag),
        .cdb_v(cdb_v), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .fu_v(fu_v), .fu_ready(fu_ready),
        .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_tag(fu_tag), .fu_rt(fu_rt)
    );

    typedef struct {
        bit            busy;
        logic [OW-1:0] op;
        logic [3:0]    rt;
        bit            av, bv;
        logic [TW-1:0] at, bt;
        logic [DW-1:0] aval, bval;
    } ent_t;

    ent_t m [N];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (!m[i].busy) return i;
        return -1;
    endfunction

    function automatic int m_offer();
        for (int i = 0; i < N; i++) if (m[i].busy && m[i].av && m[i].bv) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) m[i].busy = 1'b0;
    endtask

    task automatic compare_model();
        int f;
        int o;
        f = m_free();
        o = m_offer();
        chk("m_full", 32'(full), 32'(f < 0));
        chk("m_alloc_tag", 32'(alloc_tag), (f < 0) ? 32'd0 : 32'(f));
        chk("m_fu_v", 32'(fu_v), 32'(o >= 0));
        if (o >= 0) begin
            chk("m_fu_tag", 32'(fu_tag), 32'(o));
            chk("m_fu_op", 32'(fu_op), 32'(m[o].op));
            chk("m_fu_rt", 32'(fu_rt), 32'(m[o].rt));
            chk("m_fu_a", 32'(fu_a), 32'(m[o].aval));
            chk("m_fu_b", 32'(fu_b), 32'(m[o].bval));
        end
    endtask

    // Compare at negedge, then advance the model with the inputs seen at the edge.
    task automatic tick();
        int f;
        int o;
        @(negedge clk);
        compare_model();
        f = m_free();
        o = m_offer();
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m[i].busy && cdb_v) begin
                    if (!m[i].av && m[i].at == cdb_tag) begin m[i].av = 1'b1; m[i].aval = cdb_val; end
                    if (!m[i].bv && m[i].bt == cdb_tag) begin m[i].bv = 1'b1; m[i].bval = cdb_val; end
                end
            end
            if (o >= 0 && fu_ready) m[o].busy = 1'b0;
            if (disp_v && f >= 0) begin
                m[f].busy = 1'b1;
                m[f].op   = disp_op;
                m[f].rt   = disp_rt;
                m[f].at   = disp_a_tag;
                m[f].bt   = disp_b_tag;
                m[f].av   = !disp_a_busy || (cdb_v && cdb_tag == disp_a_tag);
                m[f].bv   = !disp_b_busy || (cdb_v && cdb_tag == disp_b_tag);
                m[f].aval = disp_a_busy ? cdb_val : disp_a_val;
                m[f].bval = disp_b_busy ? cdb_val : disp_b_val;
            end
        end
        #1;
    endtask

    task automatic idle();
        disp_v = 1'b0;
        cdb_v  = 1'b0;
    endtask

    task automatic disp(input logic [OW-1:0] op,
                        input logic ab, input logic [TW-1:0] at, input logic [DW-1:0] av,
                        input logic bb, input logic [TW-1:0] bt, input logic [DW-1:0] bv,
                        input logic [3:0] rt);
        disp_v = 1'b1; disp_op = op; disp_rt = rt;
        disp_a_busy = ab; disp_a_tag = at; disp_a_val = av;
        disp_b_busy = bb; disp_b_tag = bt; disp_b_val = bv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        clear_model();
        @(posedge clk); #1;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_fu_v", 32'(fu_v), 32'd0);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        fu_ready = 1'b0;
        disp(c_op_mov, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        disp_v = 1'b0;
        cdb_tag = '0;
        cdb_val = '0;
        do_reset();

        // Simple ready-on-dispatch issue.
        fu_ready = 1'b1;
        disp(c_op_add, 1'b0, 4'd0, 16'd5, 1'b0, 4'd0, 16'd7, 4'd3);
        tick(); idle();
        chk("t1_fu_v", 32'(fu_v), 32'd1);
        chk("t1_fu_a", 32'(fu_a), 32'd5);
        chk("t1_fu_b", 32'(fu_b), 32'd7);
        chk("t1_fu_tag", 32'(fu_tag), 32'd0);
        chk("t1_fu_op", 32'(fu_op), 32'(c_op_add));
        tick();
        chk("t1_drain", 32'(fu_v), 32'd0);

        // Operand woken by later CDB broadcast.
        disp(c_op_add, 1'b1, 4'd9, 16'd0, 1'b0, 4'd0, 16'd3, 4'd1);
        tick(); idle();
        tick();
        cdb_v = 1'b1; cdb_tag = 4'd9; cdb_val = 16'h1234;
        chk("t2_wait", 32'(fu_v), 32'd0);
        tick(); cdb_v = 1'b0;
        chk("t2_fu_v", 32'(fu_v), 32'd1);
        chk("t2_fu_a", 32'(fu_a), 32'h1234);
        chk("t2_fu_b", 32'(fu_b), 32'd3);
        tick();

        // Same-cycle bypass from CDB into dispatch.
        disp(c_op_ld, 1'b1, 4'd6, 16'd0, 1'b0, 4'd0, 16'd1, 4'd2);
        cdb_v = 1'b1; cdb_tag = 4'd6; cdb_val = 16'hBEEF;
        tick(); idle();
        chk("t3_fu_v", 32'(fu_v), 32'd1);
        chk("t3_fu_a", 32'(fu_a), 32'hBEEF);
        tick();

        // Fill, ignore dispatch while full, then drain in tag order.
        fu_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            disp(c_op_mov, 1'b0, '0, 16'(16'h100 + k), 1'b0, '0, 16'(16'h200 + k), 4'(k));
            tick();
        end
        chk("t4_full", 32'(full), 32'd1);
        disp(c_op_jmp, 1'b0, '0, 16'hDEAD, 1'b0, '0, 16'hDEAD, 4'd9);
        tick(); idle();
        chk("t4_still_full", 32'(full), 32'd1);
        chk("t4_head_a", 32'(fu_a), 32'h100);
        fu_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            chk("t4_order", 32'(fu_tag), 32'(k));
            tick();
            if (k == 0) begin
                chk("t4_full_drop", 32'(full), 32'd0);
                chk("t4_alloc_tag", 32'(alloc_tag), 32'd0);
            end
        end
        chk("t4_empty", 32'(fu_v), 32'd0);

        // Lower-index entry becoming ready preempts a held offer.
        fu_ready = 1'b0;
        disp(c_op_add, 1'b1, 4'd12, '0, 1'b0, '0, 16'd1, 4'd0); tick();
        disp(c_op_add, 1'b1, 4'd13, '0, 1'b0, '0, 16'd2, 4'd1); tick();
        disp(c_op_jeq, 1'b0, '0, 16'h22, 1'b0, '0, 16'h33, 4'd2); tick();
        idle();
        chk("t5_offer2", 32'(fu_tag), 32'd2);
        chk("t5_a2", 32'(fu_a), 32'h22);
        tick();
        chk("t5_hold_tag", 32'(fu_tag), 32'd2);
        chk("t5_hold_b", 32'(fu_b), 32'h33);
        cdb_v = 1'b1; cdb_tag = 4'd12; cdb_val = 16'h77;
        tick(); cdb_v = 1'b0;
        chk("t5_switch_tag", 32'(fu_tag), 32'd0);
        chk("t5_switch_a", 32'(fu_a), 32'h77);
        chk("t5_switch_b", 32'(fu_b), 32'd1);

        // Asynchronous reset while full and offering.
        disp(c_op_ldr, 1'b0, '0, 16'd1, 1'b0, '0, 16'd2, 4'd3);
        tick(); idle();
        chk("t6_pre_full", 32'(full), 32'd1);
        chk("t6_pre_fu_v", 32'(fu_v), 32'd1);
        #2 rst = 1'b1;
        clear_model();
        #1;
        chk("t6_async_fu_v", 32'(fu_v), 32'd0);
        chk("t6_async_full", 32'(full), 32'd0);
        chk("t6_async_alloc", 32'(alloc_tag), 32'd0);
        tick();
        rst = 1'b0;
        fu_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_issue", 32'(fu_v), 32'd0);
        end

        // Random traffic, including out-of-range producer tags.
        for (int c = 0; c < 400; c++) begin
            disp(3'($urandom_range(0, 5)),
                 ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 9)), 16'($urandom),
                 ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 9)), 16'($urandom),
                 4'($urandom_range(0, 15)));
            disp_v   = ($urandom_range(0, 1) == 1);
            cdb_v    = ($urandom_range(0, 1) == 1);
            cdb_tag  = 4'($urandom_range(0, 9));
            cdb_val  = 16'($urandom);
            fu_ready = ($urandom_range(0, 4) < 3);
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
